// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions for the memory stage: FSM encoding and the
// word-alignment mask used for data-memory addressing.
package mem_stage_ctrl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_stage_ctrl.sv
// MIPS memory-stage controller: issues load/store requests on a req/ack port,
// stalls upstream while an access is outstanding, registers MEM/WB fields.
//
// state  | meaning
// IDLE   | no access outstanding; non-memory ops pass straight to writeback
// ACCESS | request on DMReq, waiting for DMAck or timeout
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RFWEMin,
  input  logic        MtoRFSelMin,
  input  logic        DMWEMin,
  input  logic [31:0] DMdinMin,
  input  logic [31:0] ALUOutMin,
  input  logic [4:0]  RFWAMin,
  output logic        DMReq,
  output logic        DMWr,
  output logic [31:0] DMAddr,
  output logic [31:0] DMWData,
  input  logic [31:0] DMRData,
  input  logic        DMAck,
  output logic        MemStall,
  output logic        MemErr,
  output logic        RFWEWout,
  output logic        MtoRFSelWout,
  output logic [31:0] ALUOutWout,
  output logic [31:0] DMoutWout,
  output logic [4:0]  RFWAWout
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_d, wr_d, err_d;
  logic [31:0]      addr_d, wdata_d;
  logic             rfwe_d, mtorf_d;
  logic [31:0]      aluout_d, dmout_d;
  logic [4:0]       rfwa_d;
  logic             mem_op, misaligned;

  assign mem_op     = MtoRFSelMin | DMWEMin;
  assign misaligned = (ALUOutMin & ~WORD_ALIGN_MASK) != 32'd0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = DMReq;
    wr_d     = DMWr;
    addr_d   = DMAddr;
    wdata_d  = DMWData;
    err_d    = MemErr;
    rfwe_d   = 1'b0;
    mtorf_d  = 1'b0;
    aluout_d = 32'd0;
    dmout_d  = 32'd0;
    rfwa_d   = 5'd0;
    MemStall = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_op) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            MemStall = 1'b1;
            state_d  = ACCESS;
            req_d    = 1'b1;
            wr_d     = DMWEMin;
            addr_d   = ALUOutMin & WORD_ALIGN_MASK;
            wdata_d  = DMdinMin;
          end
        end else begin
          rfwe_d   = RFWEMin;
          mtorf_d  = MtoRFSelMin;
          aluout_d = ALUOutMin;
          rfwa_d   = RFWAMin;
        end
      end

      ACCESS: begin
        // Upstream holds EX/MEM during the stall, so the inputs still describe
        // the in-flight instruction when the ack arrives.
        if (DMAck) begin
          state_d  = IDLE;
          req_d    = 1'b0;
          rfwe_d   = RFWEMin;
          mtorf_d  = MtoRFSelMin;
          aluout_d = ALUOutMin;
          rfwa_d   = RFWAMin;
          dmout_d  = DMWEMin ? 32'd0 : DMRData;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          MemStall = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      DMReq        <= 1'b0;
      DMWr         <= 1'b0;
      DMAddr       <= 32'd0;
      DMWData      <= 32'd0;
      MemErr       <= 1'b0;
      RFWEWout     <= 1'b0;
      MtoRFSelWout <= 1'b0;
      ALUOutWout   <= 32'd0;
      DMoutWout    <= 32'd0;
      RFWAWout     <= 5'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      DMReq        <= req_d;
      DMWr         <= wr_d;
      DMAddr       <= addr_d;
      DMWData      <= wdata_d;
      MemErr       <= err_d;
      RFWEWout     <= rfwe_d;
      MtoRFSelWout <= mtorf_d;
      ALUOutWout   <= aluout_d;
      DMoutWout    <= dmout_d;
      RFWAWout     <= rfwa_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected writeback records are queued
// when an op is driven and popped when the op retires.
module tb_mem_stage_ctrl;
  localparam int TIMEOUT = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RFWEMin, MtoRFSelMin, DMWEMin;
  logic [31:0] DMdinMin, ALUOutMin, DMRData;
  logic [4:0]  RFWAMin;
  logic        DMAck;
  logic        DMReq, DMWr, MemStall, MemErr, RFWEWout, MtoRFSelWout;
  logic [31:0] DMAddr, DMWData, ALUOutWout, DMoutWout;
  logic [4:0]  RFWAWout;

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .RFWEMin(RFWEMin), .MtoRFSelMin(MtoRFSelMin), .DMWEMin(DMWEMin),
    .DMdinMin(DMdinMin), .ALUOutMin(ALUOutMin), .RFWAMin(RFWAMin),
    .DMReq(DMReq), .DMWr(DMWr), .DMAddr(DMAddr), .DMWData(DMWData),
    .DMRData(DMRData), .DMAck(DMAck), .MemStall(MemStall), .MemErr(MemErr),
    .RFWEWout(RFWEWout), .MtoRFSelWout(MtoRFSelWout), .ALUOutWout(ALUOutWout),
    .DMoutWout(DMoutWout), .RFWAWout(RFWAWout)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        bubble;
    logic        rfwe;
    logic        mtorf;
    logic [31:0] alu;
    logic [31:0] dmout;
    logic [4:0]  rfwa;
  } wb_t;

  wb_t sb[$];
  int  vectors = 0;
  int  errs    = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_op(input logic rfwe, input logic mtorf, input logic dmwe,
                          input logic [31:0] alu, input logic [31:0] din,
                          input logic [4:0] rfwa);
    RFWEMin = rfwe; MtoRFSelMin = mtorf; DMWEMin = dmwe;
    ALUOutMin = alu; DMdinMin = din; RFWAMin = rfwa;
  endtask

  task automatic drive_nop();
    drive_op(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_reset();
    drive_nop();
    DMAck = 1'b0; DMRData = 32'd0;
    @(posedge CLK); #1;
    vectors++;
    if ({DMReq, DMWr, DMAddr, DMWData, MemErr, RFWEWout, MtoRFSelWout,
         ALUOutWout, DMoutWout, RFWAWout} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got=%h/%h/%h/%h/%b/%b want all zero",
               DMReq, DMAddr, ALUOutWout, DMoutWout, MemErr, RFWEWout);
    end
    vectors++;
    if (MemStall !== 1'b0) begin errs++; $display("FAIL reset_stall got=%b want=0", MemStall); end
    @(negedge CLK);
    RST = 1'b0;
    tick();
  endtask

  task automatic test_nonmem();
    wb_t e;
    drive_op(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h9999_9999, 5'd5);
    sb.push_back('{1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'd0, 5'd5});
    #1;
    vectors++;
    if (MemStall !== 1'b0) begin errs++; $display("FAIL nonmem_stall got=%b want=0", MemStall); end
    tick();
    drive_nop();
    e = sb.pop_front();
    vectors++;
    if ({RFWEWout, MtoRFSelWout, ALUOutWout, DMoutWout, RFWAWout} !==
        {e.rfwe, e.mtorf, e.alu, e.dmout, e.rfwa}) begin
      errs++;
      $display("FAIL nonmem_wb got=%b %b %h %h %0d want=%b %b %h %h %0d",
               RFWEWout, MtoRFSelWout, ALUOutWout, DMoutWout, RFWAWout,
               e.rfwe, e.mtorf, e.alu, e.dmout, e.rfwa);
    end
    vectors++;
    if (DMReq !== 1'b0) begin errs++; $display("FAIL nonmem_req got=%b want=0", DMReq); end
  endtask

  task automatic test_load();
    wb_t e;
    int stalls = 0;
    drive_op(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd9);
    sb.push_back('{1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd9});
    #1;
    if (MemStall === 1'b1) stalls++;
    tick();
    vectors++;
    if ({DMReq, DMWr, DMAddr} !== {1'b1, 1'b0, 32'h0000_0100}) begin
      errs++;
      $display("FAIL load_req got req=%b wr=%b addr=%h want 1 0 00000100", DMReq, DMWr, DMAddr);
    end
    for (int n = 0; n < 3; n++) begin
      DMAck   = (n == 2);
      DMRData = (n == 2) ? 32'hDEAD_BEEF : 32'h1111_0000 + 32'(n);
      #1;
      if (MemStall === 1'b1) stalls++;
      vectors++;
      if (RFWEWout !== 1'b0 || DMReq !== 1'b1) begin
        errs++;
        $display("FAIL load_bubble cyc=%0d got rfwe=%b req=%b want 0 1", n, RFWEWout, DMReq);
      end
      tick();
    end
    DMAck = 1'b0; DMRData = 32'h7777_7777;
    drive_nop();
    vectors++;
    if (stalls != 3) begin errs++; $display("FAIL load_stall_cycles got=%0d want=3", stalls); end
    e = sb.pop_front();
    vectors++;
    if ({RFWEWout, MtoRFSelWout, ALUOutWout, DMoutWout, RFWAWout} !==
        {e.rfwe, e.mtorf, e.alu, e.dmout, e.rfwa}) begin
      errs++;
      $display("FAIL load_wb got=%b %b %h %h %0d want=%b %b %h %h %0d",
               RFWEWout, MtoRFSelWout, ALUOutWout, DMoutWout, RFWAWout,
               e.rfwe, e.mtorf, e.alu, e.dmout, e.rfwa);
    end
    vectors++;
    if (DMReq !== 1'b0) begin errs++; $display("FAIL load_req_drop got=%b want=0", DMReq); end
  endtask

  task automatic test_back_to_back();
    wb_t e;
    logic        rfwe;
    logic [31:0] alu;
    logic [4:0]  rfwa;
    for (int i = 0; i < 4; i++) begin
      rfwe = 1'($urandom_range(0, 1));
      alu  = $urandom;
      rfwa = 5'($urandom_range(0, 31));
      drive_op(rfwe, 1'b0, 1'b0, alu, $urandom, rfwa);
      DMAck   = 1'b1;        // stray ack in IDLE must be ignored
      DMRData = $urandom;
      sb.push_back('{1'b0, rfwe, 1'b0, alu, 32'd0, rfwa});
      #1;
      vectors++;
      if (MemStall !== 1'b0) begin errs++; $display("FAIL b2b_stall i=%0d got=%b want=0", i, MemStall); end
      tick();
      e = sb.pop_front();
      vectors++;
      if ({RFWEWout, MtoRFSelWout, ALUOutWout, DMoutWout, RFWAWout, DMReq} !==
          {e.rfwe, e.mtorf, e.alu, e.dmout, e.rfwa, 1'b0}) begin
        errs++;
        $display("FAIL b2b_wb i=%0d got=%b %b %h %h %0d req=%b want=%b %b %h %h %0d req=0",
                 i, RFWEWout, MtoRFSelWout, ALUOutWout, DMoutWout, RFWAWout, DMReq,
                 e.rfwe, e.mtorf, e.alu, e.dmout, e.rfwa);
      end
    end
    DMAck = 1'b0;
    drive_nop();
  endtask

  task automatic test_store();
    wb_t e;
    logic        rfwe_t [2] = '{1'b0, 1'b1};
    logic        mtorf_t[2] = '{1'b0, 1'b1};
    logic [31:0] addr_t [2] = '{32'h0000_0204, 32'h0000_0208};
    logic [31:0] data_t [2] = '{32'hCAFE_F00D, 32'h0BAD_F00D};
    logic [4:0]  rfwa_t [2] = '{5'd0, 5'd12};
    int          ackn_t [2] = '{0, 1};
    for (int t = 0; t < 2; t++) begin
      drive_op(rfwe_t[t], mtorf_t[t], 1'b1, addr_t[t], data_t[t], rfwa_t[t]);
      sb.push_back('{1'b0, rfwe_t[t], mtorf_t[t], addr_t[t], 32'd0, rfwa_t[t]});
      #1;
      vectors++;
      if (MemStall !== 1'b1) begin errs++; $display("FAIL store_stall_idle t=%0d got=%b want=1", t, MemStall); end
      tick();
      vectors++;
      if ({DMReq, DMWr, DMAddr, DMWData} !== {1'b1, 1'b1, addr_t[t], data_t[t]}) begin
        errs++;
        $display("FAIL store_req t=%0d got req=%b wr=%b addr=%h data=%h want 1 1 %h %h",
                 t, DMReq, DMWr, DMAddr, DMWData, addr_t[t], data_t[t]);
      end
      for (int n = 0; n <= ackn_t[t]; n++) begin
        DMAck   = (n == ackn_t[t]);
        DMRData = 32'h5555_AAAA;
        #1;
        vectors++;
        if (MemStall !== !DMAck) begin
          errs++;
          $display("FAIL store_stall t=%0d cyc=%0d got=%b want=%b", t, n, MemStall, !DMAck);
        end
        tick();
      end
      DMAck = 1'b0;
      drive_nop();
      e = sb.pop_front();
      vectors++;
      if ({RFWEWout, MtoRFSelWout, ALUOutWout, DMoutWout, RFWAWout, DMReq} !==
          {e.rfwe, e.mtorf, e.alu, e.dmout, e.rfwa, 1'b0}) begin
        errs++;
        $display("FAIL store_wb t=%0d got=%b %b %h %h %0d req=%b want=%b %b %h %h %0d req=0",
                 t, RFWEWout, MtoRFSelWout, ALUOutWout, DMoutWout, RFWAWout, DMReq,
                 e.rfwe, e.mtorf, e.alu, e.dmout, e.rfwa);
      end
    end
  endtask

  task automatic test_timeout();
    wb_t e;
    int req_cycles = 0;
    vectors++;
    if (MemErr !== 1'b0) begin errs++; $display("FAIL timeout_err_pre got=%b want=0", MemErr); end
    drive_op(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd3);
    sb.push_back('{1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0});
    tick();
    while (DMReq === 1'b1 && req_cycles < 20) begin
      #1;
      vectors++;
      if (MemStall !== (req_cycles < TIMEOUT - 1) || RFWEWout !== 1'b0 || MemErr !== 1'b0) begin
        errs++;
        $display("FAIL timeout_cycle k=%0d got stall=%b rfwe=%b err=%b want %b 0 0",
                 req_cycles, MemStall, RFWEWout, MemErr, req_cycles < TIMEOUT - 1);
      end
      req_cycles++;
      tick();
    end
    drive_nop();
    vectors++;
    if (req_cycles != TIMEOUT) begin
      errs++;
      $display("FAIL timeout_req_cycles got=%0d want=%0d", req_cycles, TIMEOUT);
    end
    e = sb.pop_front();
    vectors++;
    if (RFWEWout !== e.rfwe || MemErr !== 1'b1 || DMReq !== 1'b0) begin
      errs++;
      $display("FAIL timeout_abort got rfwe=%b err=%b req=%b want 0 1 0", RFWEWout, MemErr, DMReq);
    end
    drive_op(1'b1, 1'b0, 1'b0, 32'h0000_00AB, 32'h0, 5'd7);
    tick();
    drive_nop();
    vectors++;
    if ({RFWEWout, ALUOutWout, RFWAWout} !== {1'b1, 32'h0000_00AB, 5'd7}) begin
      errs++;
      $display("FAIL timeout_next_op got=%b %h %0d want=1 000000ab 7", RFWEWout, ALUOutWout, RFWAWout);
    end
  endtask

  task automatic test_reset_mid_access();
    wb_t e;
    logic [31:0] rdata = $urandom;
    drive_op(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd2);
    sb.push_back('{1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'd0, 5'd2});
    tick();
    tick();
    #2;
    RST = 1'b1;
    drive_nop();
    #1;
    sb.delete();
    vectors++;
    if ({DMReq, DMWr, DMAddr, DMWData, MemErr, RFWEWout, ALUOutWout, DMoutWout, MemStall} !== '0) begin
      errs++;
      $display("FAIL midrst_outputs got req=%b addr=%h err=%b stall=%b want all zero",
               DMReq, DMAddr, MemErr, MemStall);
    end
    @(negedge CLK);
    RST = 1'b0;
    tick();
    drive_op(1'b1, 1'b1, 1'b0, 32'h0000_040C, 32'h0, 5'd17);
    sb.push_back('{1'b0, 1'b1, 1'b1, 32'h0000_040C, rdata, 5'd17});
    tick();
    vectors++;
    if ({DMReq, DMWr, DMAddr} !== {1'b1, 1'b0, 32'h0000_040C}) begin
      errs++;
      $display("FAIL midrst_req got req=%b wr=%b addr=%h want 1 0 0000040c", DMReq, DMWr, DMAddr);
    end
    for (int n = 0; n < 2; n++) begin
      DMAck   = (n == 1);
      DMRData = (n == 1) ? rdata : ~rdata;
      tick();
    end
    DMAck = 1'b0;
    drive_nop();
    e = sb.pop_front();
    vectors++;
    if ({RFWEWout, MtoRFSelWout, ALUOutWout, DMoutWout, RFWAWout, DMReq} !==
        {e.rfwe, e.mtorf, e.alu, e.dmout, e.rfwa, 1'b0}) begin
      errs++;
      $display("FAIL midrst_load_wb got=%b %b %h %h %0d req=%b want=%b %b %h %h %0d req=0",
               RFWEWout, MtoRFSelWout, ALUOutWout, DMoutWout, RFWAWout, DMReq,
               e.rfwe, e.mtorf, e.alu, e.dmout, e.rfwa);
    end
  endtask

  task automatic test_misaligned();
    wb_t e;
    vectors++;
    if (MemErr !== 1'b0) begin errs++; $display("FAIL misal_err_pre got=%b want=0", MemErr); end
    drive_op(1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd4);
    sb.push_back('{1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0});
    #1;
    vectors++;
    if (MemStall !== 1'b0) begin errs++; $display("FAIL misal_stall got=%b want=0", MemStall); end
    tick();
    drive_nop();
    e = sb.pop_front();
    vectors++;
    if (RFWEWout !== e.rfwe || MemErr !== 1'b1 || DMReq !== 1'b0) begin
      errs++;
      $display("FAIL misal_result got rfwe=%b err=%b req=%b want 0 1 0", RFWEWout, MemErr, DMReq);
    end
    tick();
    vectors++;
    if (DMReq !== 1'b0 || MemErr !== 1'b1) begin
      errs++;
      $display("FAIL misal_sticky got req=%b err=%b want 0 1", DMReq, MemErr);
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_back_to_back();
    test_store();
    test_timeout();
    test_reset_mid_access();
    test_misaligned();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the five-stage MIPS pipeline. Consumes the execute/memory pipeline register outputs and performs loads and stores through a request/acknowledge data-memory port. Stalls the upstream pipeline while an access is outstanding and registers the results into the memory/writeback fields.

## Interface
Parameters:
- TIMEOUT, 16, maximum ACCESS cycles to wait for DMAck before aborting; legal range 2..255.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- RFWEMin  in  1  register-file write enable from the EX/MEM register.
- MtoRFSelMin  in  1  1 = load (writeback takes memory data).
- DMWEMin  in  1  1 = store.
- DMdinMin  in  32  store data.
- ALUOutMin  in  32  effective address, or ALU result for non-memory instructions.
- RFWAMin  in  5  destination register.
- DMReq  out  1  memory request, registered.
- DMWr  out  1  1 = write request, registered.
- DMAddr  out  32  word address {ALUOut[31:2],2'b00}, registered.
- DMWData  out  32  write data, registered.
- DMRData  in  32  read data; valid in the cycle DMAck=1.
- DMAck  in  1  access complete.
- MemStall  out  1  combinational; upstream holds EX/MEM while 1.
- MemErr  out  1  sticky error flag, registered.
- RFWEWout  out  1  to writeback, registered.
- MtoRFSelWout  out  1  to writeback, registered.
- ALUOutWout  out  32  to writeback, registered.
- DMoutWout  out  32  load data to writeback, registered.
- RFWAWout  out  5  to writeback, registered.

## Operation
- Memory op: MtoRFSelMin=1 or DMWEMin=1. If both are 1, the instruction is treated as a store.
- Misaligned access: a memory op with ALUOutMin[1:0]≠0.
  - Sets MemErr.
  - No request is issued.
  - Writeback fields receive a bubble (RFWEWout=0) for one cycle.
  - MemStall=0.
- FSM states: IDLE and ACCESS.
  - IDLE, non-memory op: inputs are copied to the writeback outputs at the next edge, and DMoutWout is set to 0. MemStall=0.
  - IDLE, aligned memory op: MemStall=1. At the next edge the FSM moves to ACCESS and sets DMReq=1, DMWr=DMWEMin, DMAddr and DMWData. Writeback outputs take a bubble.
  - ACCESS, DMAck=0: MemStall=1, request outputs held, timeout counter increments, writeback outputs take a bubble.
  - ACCESS, DMAck=1: MemStall=0. At the next edge:
    - DMReq=0 and the FSM returns to IDLE.
    - Writeback outputs take the held instruction's RFWE, MtoRFSel, ALUOut and RFWA.
    - DMoutWout takes DMRData for a load, or 0 for a store.
  - ACCESS, counter reaches TIMEOUT-1 with DMAck=0: abort. MemStall=0. At the next edge DMReq=0, MemErr=1, the writeback outputs take a bubble and the FSM returns to IDLE.
- Inputs are held stable by upstream during the stall, so no input copy is needed; the counter is cleared on entry to ACCESS.
- MemErr is cleared only by RST.
- DMAck arriving in IDLE is ignored.

## Timing
- Reset values: state IDLE, all registered outputs 0, counter 0; MemStall=0 after reset.
- RST asserted mid-access: the request drops immediately. Memory must tolerate an abandoned request.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: 2+N cycles for an ack N cycles after DMReq rises (N=0 means ack in the first ACCESS cycle).
- DMReq stays high until the edge after DMAck. At most one outstanding request exists.
- Timeout abort occurs after exactly TIMEOUT ACCESS cycles.

## Structure
- Shared pipeline package holds the FSM state encoding (IDLE=1'b0, ACCESS=1'b1) and a 32-bit word-alignment mask constant.
- No sub-module is needed. The timeout counter is a small inline register of width clog2(TIMEOUT).

## Test plan
- Non-memory op: ALU result 0x0000_1234, RFWA=5, RFWE=1 → next edge RFWEWout=1, ALUOutWout=0x1234, DMoutWout=0, MemStall never high.
- Load at 0x100, ack with DMRData=0xDEADBEEF two cycles after DMReq rises → MemStall high for 3 cycles; DMoutWout=0xDEADBEEF, MtoRFSelWout=1, RFWAWout correct; bubbles during stall.
- Store 0xCAFEF00D at 0x204, ack in the first ACCESS cycle → DMWr=1, DMAddr=0x204, DMWData=0xCAFEF00D; completes in 2 cycles with RFWEWout=0.
- Load at 0x102 → MemErr=1, DMReq never asserted, one bubble, MemStall=0.
- No ack with TIMEOUT=4 → DMReq high exactly 4 cycles then drops; MemErr=1; the next op proceeds normally.
- RST pulsed while in ACCESS → all outputs 0 asynchronously; the next aligned load completes correctly.
